// File: rtl/inst_type_encoder.sv
// Instruction-type encoder: classifies RV32I words by opcode into a one-hot
// control code and hands each entry downstream through a 2-entry skid buffer
// with a registered output.
module inst_type_encoder #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [9:0]      out_code,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } state_t;

    state_t state_q, state_d;

    logic [9:0]      out_code_q, out_code_d;
    logic            out_ill_q, out_ill_d;
    logic [XLEN-1:0] out_inst_q, out_inst_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;

    logic [9:0]      skid_code_q, skid_code_d;
    logic            skid_ill_q, skid_ill_d;
    logic [XLEN-1:0] skid_inst_q, skid_inst_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;

    logic [9:0] dec_code;
    logic       dec_ill;
    logic       accept;
    logic       pop;

    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Opcode classification of the incoming word; FENCE is a legal no-op.
    always_comb begin
        dec_code = '0;
        dec_ill  = 1'b0;
        case (in_inst[6:0])
            7'b1101111: dec_code = 10'b00_0000_0001;
            7'b1100111: dec_code = 10'b00_0000_0010;
            7'b0110111: dec_code = 10'b00_0000_0100;
            7'b0010111: dec_code = 10'b00_0000_1000;
            7'b1100011: dec_code = 10'b00_0001_0000;
            7'b0110011: dec_code = 10'b00_0010_0000;
            7'b0100011: dec_code = 10'b00_0100_0000;
            7'b0010011: dec_code = 10'b00_1000_0000;
            7'b0000011: dec_code = 10'b01_0000_0000;
            7'b1110011: dec_code = 10'b10_0000_0000;
            7'b0001111: dec_code = '0;
            default:    dec_ill  = 1'b1;
        endcase
    end

    // Skid-buffer next state and register loads; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        out_code_d  = out_code_q;
        out_ill_d   = out_ill_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        skid_code_d = skid_code_q;
        skid_ill_d  = skid_ill_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;

        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    out_code_d = dec_code;
                    out_ill_d  = dec_ill;
                    out_inst_d = in_inst;
                    out_pc_d   = in_pc;
                    state_d    = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && pop) begin
                    out_code_d = dec_code;
                    out_ill_d  = dec_ill;
                    out_inst_d = in_inst;
                    out_pc_d   = in_pc;
                end else if (accept) begin
                    skid_code_d = dec_code;
                    skid_ill_d  = dec_ill;
                    skid_inst_d = in_inst;
                    skid_pc_d   = in_pc;
                    state_d     = S_FULL;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop) begin
                    out_code_d = skid_code_q;
                    out_ill_d  = skid_ill_q;
                    out_inst_d = skid_inst_q;
                    out_pc_d   = skid_pc_q;
                    state_d    = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        if (flush) begin
            state_d = S_EMPTY;
        end
    end

    // State and data registers; reset clears data as well as state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            out_code_q  <= '0;
            out_ill_q   <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
            skid_code_q <= '0;
            skid_ill_q  <= 1'b0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_code_q  <= out_code_d;
            out_ill_q   <= out_ill_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            skid_code_q <= skid_code_d;
            skid_ill_q  <= skid_ill_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign out_code    = out_code_q;
    assign out_illegal = out_ill_q;
    assign out_inst    = out_inst_q;
    assign out_pc      = out_pc_q;

endmodule

// File: tb/tb_inst_type_encoder.sv
// Scoreboard bench for inst_type_encoder: the driver records hand-computed
// expectations for each offered word, the negedge monitor queues them on
// accept and compares on every pop.
module tb_inst_type_encoder;

    typedef struct packed {
        logic [9:0]  code;
        logic        ill;
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_code;
    logic        out_illegal;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    logic [9:0]  exp_code = '0;
    logic        exp_ill = 1'b0;
    logic [31:0] pc_ctr = 32'h0000_1000;
    logic        mon_en = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          pop_cnt = 0;
    entry_t      sb[$];

    // Hand-computed classification table.
    logic [31:0] tbl_w [15] = '{32'h0000006F, 32'h00100093, 32'h34029073, 32'h0000000F,
                                32'h00000000, 32'h0000007B, 32'h00000037, 32'h00000017,
                                32'h00000067, 32'h00000063, 32'h00000033, 32'h00000023,
                                32'h00000003, 32'h00000073, 32'h00000071};
    logic [9:0]  tbl_c [15] = '{10'h001, 10'h080, 10'h200, 10'h000,
                                10'h000, 10'h000, 10'h004, 10'h008,
                                10'h002, 10'h010, 10'h020, 10'h040,
                                10'h100, 10'h200, 10'h000};
    logic        tbl_i [15] = '{1'b0, 1'b0, 1'b0, 1'b0,
                                1'b1, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b1};

    inst_type_encoder #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .out_illegal (out_illegal),
        .out_inst    (out_inst),
        .out_pc      (out_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus: inputs set 1 unit after posedge, held until the next one.
    task automatic cyc(input logic v, input logic [31:0] w, input logic [9:0] c,
                       input logic il, input logic ordy, input logic fl,
                       input logic rst, input logic probe);
        logic ir;
        in_valid  = v;
        in_inst   = w;
        in_pc     = pc_ctr;
        exp_code  = c;
        exp_ill   = il;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        pc_ctr    = pc_ctr + 32'd4;
        if (probe) begin
            #2;
            ir = in_ready;
            out_ready = ~ordy;
            #1;
            check("in_ready_indep_of_out_ready", {63'd0, in_ready}, {63'd0, ir});
            out_ready = ordy;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic ordy);
        cyc(1'b1, tbl_w[idx], tbl_c[idx], tbl_i[idx], ordy, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 32'h0, 10'h0, 1'b0, ordy, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_out_code"}, {54'd0, out_code}, 64'd0);
        check({tag, "_out_illegal"}, {63'd0, out_illegal}, 64'd0);
        check({tag, "_out_inst"}, {32'd0, out_inst}, 64'd0);
        check({tag, "_out_pc"}, {32'd0, out_pc}, 64'd0);
    endtask

    // Monitor: compare occupancy, check popped entries, then apply this cycle's handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            entry_t e;
            check("out_valid_vs_model", {63'd0, out_valid}, {63'd0, (sb.size() != 0)});
            check("in_ready_vs_model", {63'd0, in_ready}, {63'd0, (sb.size() < 2)});
            if (out_valid) begin
                check("code_onehot_or_zero", {63'd0, ($countones(out_code) <= 1)}, 64'd1);
                check("code_with_illegal", {63'd0, ((out_code != 10'd0) && out_illegal)}, 64'd0);
            end
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_output_inst", {32'd0, out_inst}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("pop_code", {54'd0, out_code}, {54'd0, e.code});
                    check("pop_illegal", {63'd0, out_illegal}, {63'd0, e.ill});
                    check("pop_inst", {32'd0, out_inst}, {32'd0, e.inst});
                    check("pop_pc", {32'd0, out_pc}, {32'd0, e.pc});
                end
            end
            if (reset || flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                e.code = exp_code;
                e.ill  = exp_ill;
                e.inst = in_inst;
                e.pc   = in_pc;
                sb.push_back(e);
            end
        end
    end

    initial begin
        int pops0;
        int idx;
        logic [31:0] w;
        logic v, r, f, p;

        cyc(1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        mon_en = 1'b1;
        cyc(1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_cleared("reset");

        // Legal stream with out_ready high: one-cycle latency each.
        for (int i = 0; i < 4; i++) begin
            send(i, 1'b1);
            check("stream_valid", {63'd0, out_valid}, 64'd1);
            check("stream_inst", {32'd0, out_inst}, {32'd0, tbl_w[i]});
            check("stream_code", {54'd0, out_code}, {54'd0, tbl_c[i]});
            check("stream_illegal", {63'd0, out_illegal}, 64'd0);
        end
        idle(1'b1);

        // Illegal words.
        for (int i = 4; i < 6; i++) begin
            send(i, 1'b1);
            check("illegal_code", {54'd0, out_code}, 64'd0);
            check("illegal_flag", {63'd0, out_illegal}, 64'd1);
        end
        idle(1'b1);

        // Backpressure: LUI then AUIPC held, then drained in order.
        send(6, 1'b0);
        check("bp_ready_after_first", {63'd0, in_ready}, 64'd1);
        send(7, 1'b0);
        check("bp_ready_after_second", {63'd0, in_ready}, 64'd0);
        check("bp_code_held", {54'd0, out_code}, 64'h004);
        send(0, 1'b0);
        check("bp_code_still_held", {54'd0, out_code}, 64'h004);
        check("bp_inst_still_held", {32'd0, out_inst}, 64'h37);
        idle(1'b1);
        check("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
        check("bp_second_code", {54'd0, out_code}, 64'h008);
        idle(1'b1);
        check("bp_drained", {63'd0, out_valid}, 64'd0);

        // Flush while FULL with a simultaneous offer.
        send(6, 1'b0);
        send(7, 1'b0);
        cyc(1'b1, tbl_w[0], tbl_c[0], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        pops0 = pop_cnt;
        send(8, 1'b1);
        check("post_flush_code", {54'd0, out_code}, 64'h002);
        idle(1'b1);
        idle(1'b1);
        check("post_flush_single_output", pop_cnt - pops0, 64'd1);

        // Reset in ONE.
        send(10, 1'b0);
        check("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        cyc(1'b1, tbl_w[11], tbl_c[11], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_cleared("midreset");

        // Random traffic; upper bits randomised so only the opcode matters.
        for (int n = 0; n < 10000; n++) begin
            idx = $urandom_range(0, 14);
            w = tbl_w[idx] | ($urandom & 32'hFFFF_FF80);
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 31) == 0);
            p = ($urandom_range(0, 15) == 0);
            cyc(v, w, tbl_c[idx], tbl_i[idx], r, f, 1'b0, p);
        end

        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check("final_scoreboard_empty", sb.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_type_encoder.md
# inst_type_encoder

Decode-side producer of the 10-bit one-hot instruction-type code consumed by the control-unit signal generators (ALU operand selects, write-back selects, etc.). Classifies each fetched RV32I instruction word by opcode, registers the code alongside the instruction and PC, and hands it downstream through a valid/ready interface. A 2-entry skid buffer keeps full throughput under backpressure and provides a registered output.

## Interface
- XLEN, 32, width of instruction and PC
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard all buffered entries (branch/trap redirect)
- in_valid  input  1  upstream offers in_inst/in_pc
- in_ready  output  1  block can accept this cycle
- in_inst  input  XLEN  fetched instruction word
- in_pc  input  XLEN  PC of in_inst
- out_valid  output  1  out_* fields hold a valid entry
- out_ready  input  1  downstream consumes entry this cycle
- out_code  output  10  one-hot instruction-type code
- out_illegal  output  1  opcode not recognised
- out_inst  output  XLEN  instruction word of the entry
- out_pc  output  XLEN  PC of the entry

## Operation
- Code map, on in_inst[6:0]:
  - bit0: JAL 1101111
  - bit1: JALR 1100111
  - bit2: LUI 0110111
  - bit3: AUIPC 0010111
  - bit4: BRANCH 1100011
  - bit5: OP 0110011
  - bit6: STORE 0100011
  - bit7: OP-IMM 0010011
  - bit8: LOAD 0000011
  - bit9: SYSTEM/CSR 1110011
- FENCE 0001111: code 0, illegal 0 (NOP downstream).
- Any other opcode, including in_inst[1:0] != 2'b11: code 0, illegal 1.
- out_code always has at most one bit set; never one bit set together with illegal=1.
- Classification is computed from in_inst when the entry is accepted and stored with it; no re-decode at output.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Buffer state machine, with an output register (OUT) and a skid register (SKID):
  - EMPTY: out_valid=0, in_ready=1. Accept → ONE (entry into OUT).
  - ONE: out_valid=1, in_ready=1. Accept & pop → ONE (new entry into OUT). Accept & !pop → FULL (new entry into SKID). Pop & !accept → EMPTY. Neither → ONE.
  - FULL: out_valid=1, in_ready=0. Pop → ONE (SKID moves to OUT). Otherwise hold.
- in_ready = (state != FULL), from state only; no combinational path from out_ready.
- Order is strictly preserved: the SKID entry is always younger than the OUT entry.
- flush: next state EMPTY and both entries discarded. Flush has priority over an accept or pop in the same cycle; an in_valid entry offered during flush is dropped, although in_ready may read 1.
- reset: same effect as flush, plus all data registers are cleared.

## Timing
- Reset values: state EMPTY; out_valid 0; in_ready 1; out_code 0; out_illegal 0; out_inst 0; out_pc 0. SKID contents are 0.
- Latency: accept in cycle N → out_valid and fields visible in cycle N+1.
- Throughput: 1 entry/cycle while out_ready is held at 1.
- While out_valid=1 and out_ready=0, all out_* fields are stable.
- in_ready falls the cycle after an accept without pop while in ONE. It rises the cycle after a pop from FULL.
- After flush or reset, out_valid=0 in the next cycle. Accepts resume that same cycle.
- Data registers other than valid/state need not be cleared on flush. They are cleared on reset.

## Test plan
- Reset, then stream 0x0000006F, 0x00100093, 0x34029073, 0x0000000F with out_ready=1 → one-cycle latency each. Codes in order: 10'b0000000001, 10'b0010000000, 10'b1000000000, 10'b0000000000. out_illegal is 0 throughout; out_pc matches in_pc.
- Illegal words 0x00000000 and 0x0000007B → out_code 0, out_illegal 1.
- Backpressure: out_ready=0 while sending 0x00000037 then 0x00000017 → in_ready drops after the 2nd accept, out_code holds 10'b0000000100. Raise out_ready → codes 10'b0000000100 then 10'b0000001000 in order, with nothing lost or duplicated.
- Flush in FULL with simultaneous in_valid → next cycle out_valid=0, no entry emerges. The next accepted word is the only output.
- Reset asserted mid-stream in ONE → next cycle out_valid=0, in_ready=1, and all out_* fields are 0.
- Random in_valid/out_ready/flush, 10k cycles → output sequence equals a scoreboard of accepted, non-flushed words. out_code is always one-hot or zero, and in_ready has no dependence on out_ready within a cycle.
